// File: rtl/lz77_match_ctrl.sv
// lz77_match_ctrl: walks every search offset through the shared comparator and emits the longest-match token
module lz77_match_ctrl #(
  parameter int SEARCH_LEN = 9,
  parameter int OFS_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [8*SEARCH_LEN-1:0] srch_win,
  input  logic [OFS_W-1:0]        srch_cnt,
  input  logic [63:0]             lah_win,
  input  logic [3:0]              lah_cnt,
  output logic                    busy,
  output logic [63:0]             cmp_buff1,
  output logic [63:0]             cmp_buff2,
  input  logic [3:0]              cmp_len,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OFS_W-1:0]        out_offset,
  output logic [3:0]              out_len,
  output logic [7:0]              out_char
);
  localparam int HW = 8*SEARCH_LEN + 64;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state;
  logic [8*SEARCH_LEN-1:0] sw;
  logic [OFS_W-1:0] sc, ofs, best_ofs;
  logic [63:0] lw, lr, lsh;
  logic [3:0] lc, best_len, cap, eff;
  logic [HW-1:0] hv, hs;
  always_comb begin
    lr = '0;
    for (int j = 0; j < 8; j++) lr[8*(7-j) +: 8] = lw[8*j +: 8];
  end
  // {sw, lr} is the byte stream oldest-first: search byte SEARCH_LEN-1 at the MSB, then lookahead in order,
  // so the candidate for offset ofs is the 8-byte window starting SEARCH_LEN-1-ofs bytes from the top
  assign hv = {sw, lr};
  assign hs = hv << (8*(SEARCH_LEN-1-int'(ofs)));
  assign cmp_buff1 = (state == SCAN) ? hs[HW-1 -: 64] : '0;
  assign cmp_buff2 = (state == SCAN) ? lr : '0;
  assign cap = lc - 4'd1;
  assign eff = (cmp_len < cap) ? cmp_len : cap;
  assign lsh = lw >> (8*int'(best_len));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      out_valid <= 1'b0;
      out_offset <= '0;
      out_len <= '0;
      out_char <= '0;
      ofs <= '0;
      best_len <= '0;
      best_ofs <= '0;
      sw <= '0;
      sc <= '0;
      lw <= '0;
      lc <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sw <= srch_win;
          sc <= srch_cnt;
          lw <= lah_win;
          lc <= lah_cnt;
          best_len <= '0;
          best_ofs <= '0;
          ofs <= '0;
          busy <= 1'b1;
          state <= (srch_cnt == '0) ? DONE : SCAN;
        end
        SCAN: begin
          if (eff > best_len) begin
            best_len <= eff;
            best_ofs <= ofs;
          end
          if (ofs == sc - OFS_W'(1) || eff == cap) state <= DONE;
          else ofs <= ofs + OFS_W'(1);
        end
        DONE: if (!out_valid) begin
          out_valid <= 1'b1;
          out_offset <= best_ofs;
          out_len <= best_len;
          out_char <= lsh[7:0];
        end else if (out_ready) begin
          out_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lz77_match_ctrl.sv
// tb_lz77_match_ctrl: directed vectors, queued expected tokens checked by an independent handshake monitor
module tb_lz77_match_ctrl;
  logic clk = 1'b0;
  logic reset, start, out_ready, busy, out_valid;
  logic [71:0] srch_win;
  logic [3:0] srch_cnt, lah_cnt, cmp_len, out_offset, out_len;
  logic [63:0] lah_win, cmp_buff1, cmp_buff2;
  logic [7:0] out_char;
  logic [15:0] q[$];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  lz77_match_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .srch_win(srch_win), .srch_cnt(srch_cnt),
    .lah_win(lah_win), .lah_cnt(lah_cnt), .busy(busy), .cmp_buff1(cmp_buff1),
    .cmp_buff2(cmp_buff2), .cmp_len(cmp_len), .out_valid(out_valid), .out_ready(out_ready),
    .out_offset(out_offset), .out_len(out_len), .out_char(out_char)
  );
  // comparator: count equal leading bytes, MSB byte first
  always_comb begin
    logic stop;
    stop = 1'b0;
    cmp_len = 4'd0;
    for (int j = 0; j < 8; j++) begin
      if (!stop && cmp_buff1[63-8*j -: 8] == cmp_buff2[63-8*j -: 8]) cmp_len = cmp_len + 4'd1;
      else stop = 1'b1;
    end
  end
  function automatic logic [63:0] rv(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = s[63-8*j -: 8];
    return r;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [15:0] e;
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_token", {out_offset, out_len, out_char}, 16'hffff);
      else begin
        e = q.pop_front();
        chk("token", {out_offset, out_len, out_char}, e);
      end
    end
  end
  task automatic go(input logic [71:0] s, input logic [3:0] scn, input logic [63:0] l, input logic [3:0] lcn,
                    input logic [15:0] tok, input int lat, input int hold);
    int n;
    logic [15:0] held;
    q.push_back(tok);
    srch_win = s;
    srch_cnt = scn;
    lah_win = l;
    lah_cnt = lcn;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    chk("latency", 64'(n), 64'(lat));
    chk("busy_valid", {busy, out_valid}, 2'b11);
    held = {out_offset, out_len, out_char};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      start = (i == 2);
      if (i == 2) begin
        srch_cnt = 4'd0;
        lah_win = rv("ZZZZZZZZ");
        lah_cnt = 4'd1;
      end
      @(negedge clk);
      chk("hold_valid_busy", {out_valid, busy}, 2'b11);
      chk("hold_token", {out_offset, out_len, out_char}, held);
    end
    @(posedge clk);
    #1 start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("post_hs", {busy, out_valid}, 2'b00);
    if (hold > 0) begin
      repeat (4) @(negedge clk);
      chk("ignored_start", {busy, out_valid}, 2'b00);
    end
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    srch_win = '0;
    srch_cnt = '0;
    lah_win = '0;
    lah_cnt = 4'd8;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_token", {out_offset, out_len, out_char}, 16'h0);
    chk("rst_cmp1", cmp_buff1, 64'h0);
    go({48'h0, "abc"}, 4'd3, rv("abcXabcX"), 4'd8, {4'd2, 4'd3, "X"}, 5, 0);
    go({64'h0, "a"}, 4'd1, rv("aaaaaaab"), 4'd8, {4'd0, 4'd7, "b"}, 3, 0);
    go({40'h0, "abab"}, 4'd4, rv("abZdefgh"), 4'd8, {4'd1, 4'd2, "Z"}, 6, 0);
    go(72'h0, 4'd0, rv("Qxxxxxxx"), 4'd5, {4'd0, 4'd0, "Q"}, 2, 0);
    go({64'h0, "m"}, 4'd1, rv("mmmmmmmm"), 4'd1, {4'd0, 4'd0, "m"}, 3, 0);
    go({48'h0, "abc"}, 4'd3, rv("abcXabcX"), 4'd8, {4'd2, 4'd3, "X"}, 5, 5);
    srch_win = {48'h0, "abc"};
    srch_cnt = 4'd3;
    lah_win = rv("abcXabcX");
    lah_cnt = 4'd8;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("scan_cmp1", cmp_buff1, "bcabcXab");
    chk("scan_cmp2", cmp_buff2, "abcXabcX");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_bv", {busy, out_valid}, 2'b00);
    chk("mid_rst_token", {out_offset, out_len, out_char}, 16'h0);
    chk("mid_rst_cmp", {cmp_buff1, cmp_buff2} == '0, 1'b1);
    go({64'h0, "a"}, 4'd1, rv("aaaaaaab"), 4'd8, {4'd0, 4'd7, "b"}, 3, 0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lz77_match_ctrl.md
Name: lz77_match_ctrl

Overview:
Sequencer that drives the shared 8-byte match comparator across every valid search-window offset for one LZ77 encoding step. It tracks the longest match, with ties going to the smallest offset. It then emits one (offset, length, next_char) token through a valid/ready handshake. It sits between the window/lookahead shift registers and the token packer.

Parameters:
SEARCH_LEN, 9, number of search-window bytes (offsets 0..SEARCH_LEN-1)
OFS_W, 4, width of offset and search-count fields; must satisfy 2^OFS_W > SEARCH_LEN

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request one match search; accepted only in IDLE
srch_win  in  8*SEARCH_LEN  search bytes; byte k = bits[8k+7:8k]; k=0 is most recent
srch_cnt  in  OFS_W  valid search bytes, 0..SEARCH_LEN
lah_win  in  64  lookahead; byte j = bits[8j+7:8j]; j=0 is first to encode
lah_cnt  in  4  valid lookahead bytes, 1..8
busy  out  1  high from start acceptance until token handshake completes
cmp_buff1  out  64  candidate sequence to comparator
cmp_buff2  out  64  lookahead to comparator
cmp_len  in  4  comparator result: 0..8 leading equal bytes, MSB byte first
out_valid  out  1  token valid
out_ready  in  1  token accepted when out_valid && out_ready
out_offset  out  OFS_W  best offset
out_len  out  4  match length 0..7
out_char  out  8  lookahead byte [out_len]

Behaviour:
- Reset (sync, active-high): state=IDLE. busy, out_valid, out_offset, out_len, out_char, the offset counter and the best-match registers all go to 0. Reset takes priority in every state, including mid-SCAN and DONE; any pending token is discarded.
- States:
  - IDLE: if start, latch srch_win, srch_cnt, lah_win, lah_cnt. Clear best_len/best_ofs. Set ofs=0 and busy=1.
    - If srch_cnt==0, go to DONE.
    - Otherwise go to SCAN.
  - SCAN: one offset per cycle.
    - Candidate seq[j] = srch byte (ofs-j) for j<=ofs; otherwise lah byte (j-ofs-1). This allows overlapping matches into the lookahead.
    - cmp_buff1 byte lane (7-j) = seq[j]; cmp_buff2 byte lane (7-j) = lah byte j. First byte goes in bits[63:56].
    - Comparator is combinational; cmp_len is sampled in the same cycle.
    - cap = lah_cnt-1 (one byte is reserved for next_char). eff = min(cmp_len, cap).
    - If eff > best_len (strictly greater), then best_len=eff and best_ofs=ofs.
    - Exit to DONE when ofs==srch_cnt-1 or eff==cap (early exit). Otherwise ofs++.
  - DONE: out_valid=1. out_offset=best_ofs, out_len=best_len, out_char=lah byte[best_len], all registered and stable while valid.
    - On out_ready: out_valid=0, busy=0, go to IDLE.
    - Backpressure holds the token indefinitely.
- cmp_buff1/cmp_buff2 are don't-care outside SCAN; drive them to 0.
- start while busy is ignored; it is not queued. Inputs are not sampled after the accept cycle.
- Latency: start cycle + S scan cycles + 1 to out_valid. S = number of offsets evaluated: 1..srch_cnt, 0 if srch_cnt==0.
- No match (all eff==0): out_offset=0, out_len=0, out_char=lah byte 0.
- lah_cnt==1: cap=0, so the first scan cycle exits with len 0.
- Comparator mismatches in lanes beyond cap are irrelevant because of the min clamp.

Test Plan:
- Search bytes k0..k2 = "c","b","a", srch_cnt=3; lah="abcXabcX", lah_cnt=8 -> 3 scan cycles. Token offset=2, len=3, char='X'.
- Overlap: srch byte0='a', srch_cnt=1; lah="aaaaaaab", lah_cnt=8 -> early exit after 1 scan cycle. Token offset=0, len=7, char='b'.
- Tie: srch = "ab","ab" at offsets 1 and 3 (bytes "b","a","b","a"), srch_cnt=4; lah="abZ....", lah_cnt=8 -> offset=1, len=2, char='Z' (smaller offset wins).
- srch_cnt=0, lah="Q.......", lah_cnt=5 -> no SCAN cycles; out_valid 2 cycles after start. Token offset=0, len=0, char='Q'.
- Backpressure: out_ready low 5 cycles -> out_valid and token fields held constant. A start pulsed during that window is ignored, and busy stays 1.
- Reset asserted in the 2nd SCAN cycle -> next cycle busy=0, out_valid=0, all outputs 0. A new start afterwards completes normally.
